// File: rtl/usb_tx_pkg.sv
// Shared types and CRC-16/USB helpers for the USB transmit scheduler.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CRC_LO = 2'd2,
        CRC_HI = 2'd3
    } tx_state_t;

    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    // Reflected CRC-16: the byte is consumed LSB first.
    function automatic logic [15:0] crc16_byte_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC16_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational one-byte CRC-16/USB update.
module usb_crc16_byte
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] next_crc
);

    assign next_crc = crc16_byte_step(crc, data);

endmodule

// File: rtl/usb_tx_scheduler.sv
// Round-robin scheduler sharing one USB transmit channel among NUM_REQ sources;
// streams the winner's payload and appends its CRC-16 (low byte first).
module usb_tx_scheduler
    import usb_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        data_ack,
    output logic                      tx_valid,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic                      tx_last,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    tx_state_t          state_q;
    tx_state_t          state_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   last_winner_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   byte_cnt_q;
    logic [15:0]        crc_q;
    logic [15:0]        crc_next;

    logic [LEN_W-1:0]   len_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [DATA_W-1:0]  cur_byte;

    logic               arb_found;
    logic [IDX_W-1:0]   arb_pick;
    logic [IDX_W-1:0]   arb_cand;
    logic               hs;
    logic               last_byte;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // During a packet last_winner_q is the granted source.
    assign cur_byte = data_arr[last_winner_q];

    // Scan upward from the source after the previous winner, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_cand = IDX_W'((int'(last_winner_q) + i) % NUM_REQ);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_pick  = arb_cand;
            end
        end
    end

    usb_crc16_byte u_crc (
        .crc      (crc_q),
        .data     (cur_byte),
        .next_crc (crc_next)
    );

    assign hs        = tx_valid && tx_ready;
    assign last_byte = (byte_cnt_q == (len_q - LEN_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = (len_arr[arb_pick] != '0) ? DATA : CRC_LO;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                if (tx_ready && last_byte) begin
                    state_d = CRC_LO;
                end
            end
            CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[7:0];
                if (tx_ready) begin
                    state_d = CRC_HI;
                end
            end
            CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[15:8];
                tx_last  = 1'b1;
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q         <= '0;
            last_winner_q <= IDX_W'(NUM_REQ - 1);
            len_q         <= '0;
            byte_cnt_q    <= '0;
            crc_q         <= CRC16_INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        gnt_q         <= NUM_REQ'(1) << arb_pick;
                        last_winner_q <= arb_pick;
                        len_q         <= len_arr[arb_pick];
                        byte_cnt_q    <= '0;
                        crc_q         <= CRC16_INIT;
                    end
                end
                DATA: begin
                    if (hs) begin
                        crc_q      <= crc_next;
                        byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                    end
                end
                CRC_HI: begin
                    if (hs) begin
                        gnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign data_ack = (state_q == DATA && tx_ready) ? gnt_q : '0;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Scoreboard bench for usb_tx_scheduler: a packet-level reference model predicts
// grant order and beat contents; a negedge monitor pops and compares.
module tb_usb_tx_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = 4;
    localparam int MAXPK   = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        data_ack;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic                      tx_last;
    logic                      busy;

    usb_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_len  (req_len),
        .req_data (req_data),
        .gnt      (gnt),
        .data_ack (data_ack),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]         data;
        logic               last;
        logic [NUM_REQ-1:0] gnt;
        logic [NUM_REQ-1:0] ack;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic [7:0] pay [NUM_REQ][MAXPK][16];
    int  lenv       [NUM_REQ][MAXPK];
    int  npkt       [NUM_REQ];
    int  cur_pkt    [NUM_REQ];
    int  ptr        [NUM_REQ];
    bit  drop_early [NUM_REQ];
    bit  dropped    [NUM_REQ];
    int  ack_cnt    [NUM_REQ];
    int  exp_ack    [NUM_REQ];
    bit  ack_seen   [NUM_REQ];
    bit  last_seen  [NUM_REQ];
    int  model_lw;
    int  ready_mode;
    int  ready_phase;
    bit  in_reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ d[k];
            c  = {1'b0, c[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
        end
        return c;
    endfunction

    // Source emulation: present the current packet's length and byte.
    task automatic drive_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cur_pkt[i] < npkt[i]) begin
                req[i]                      = !dropped[i];
                req_len[i*LEN_W +: LEN_W]   = LEN_W'(lenv[i][cur_pkt[i]]);
                req_data[i*DATA_W +: DATA_W] = pay[i][cur_pkt[i]][ptr[i]];
            end else begin
                req[i]                      = 1'b0;
                req_len[i*LEN_W +: LEN_W]   = '0;
                req_data[i*DATA_W +: DATA_W] = 8'h00;
            end
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < NUM_REQ; i++) begin
            npkt[i]       = 0;
            drop_early[i] = 1'b0;
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        lenv[s][npkt[s]] = len;
        for (int b = 0; b < 16; b++) pay[s][npkt[s]][b] = 8'($urandom);
        npkt[s]++;
    endtask

    // Round-robin over sources with packets still pending; each held request
    // is served in rotation starting after the previous winner.
    task automatic predict();
        int          rem [NUM_REQ];
        int          pk  [NUM_REQ];
        int          total;
        int          s;
        int          j;
        logic [15:0] c;
        beat_t       b;
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i]     = npkt[i];
            pk[i]      = 0;
            exp_ack[i] = 0;
            total     += npkt[i];
        end
        repeat (total) begin
            s = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (model_lw + k) % NUM_REQ;
                if (s < 0 && rem[j] > 0) s = j;
            end
            c = 16'hFFFF;
            for (int n = 0; n < lenv[s][pk[s]]; n++) begin
                b.data = pay[s][pk[s]][n];
                b.last = 1'b0;
                b.gnt  = NUM_REQ'(1) << s;
                b.ack  = NUM_REQ'(1) << s;
                exp_q.push_back(b);
                c = ref_crc(c, pay[s][pk[s]][n]);
            end
            b.data = ~c[7:0];
            b.last = 1'b0;
            b.gnt  = NUM_REQ'(1) << s;
            b.ack  = '0;
            exp_q.push_back(b);
            b.data = ~c[15:8];
            b.last = 1'b1;
            exp_q.push_back(b);
            exp_ack[s] += lenv[s][pk[s]];
            rem[s]--;
            pk[s]++;
            model_lw = s;
        end
    endtask

    task automatic start_plan();
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_pkt[i]   = 0;
            ptr[i]       = 0;
            dropped[i]   = 1'b0;
            ack_cnt[i]   = 0;
            ack_seen[i]  = 1'b0;
            last_seen[i] = 1'b0;
        end
        predict();
        drive_sources();
    endtask

    task automatic run_scenario(input int mode);
        int cyc;
        ready_mode = mode;
        @(posedge clk);
        #2;
        start_plan();
        cyc = 0;
        while ((exp_q.size() != 0 || busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) check("ack_count", 32'(ack_cnt[i]), 32'(exp_ack[i]));
        clear_plan();
    endtask

    // Sources advance after the edge that consumed their byte; PHY readiness.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!in_reset) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (ack_seen[i]) begin
                        ptr[i]++;
                        if (drop_early[i]) dropped[i] = 1'b1;
                    end
                    if (last_seen[i]) begin
                        cur_pkt[i]++;
                        ptr[i] = 0;
                    end
                    ack_seen[i]  = 1'b0;
                    last_seen[i] = 1'b0;
                end
                drive_sources();
            end
            case (ready_mode)
                1:       tx_ready = (ready_phase % 3 == 0);
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b1;
            endcase
            ready_phase++;
        end
    end

    // Monitor
    initial begin
        bit    prev_stall;
        bit    prev_last_hs;
        beat_t e;
        prev_stall   = 1'b0;
        prev_last_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                prev_stall   = 1'b0;
                prev_last_hs = 1'b0;
            end else begin
                if (prev_stall) check("hold_valid", 32'(tx_valid), 32'd1);
                if (prev_last_hs) begin
                    check("gap_gnt", 32'(gnt), 32'd0);
                    check("gap_busy", 32'(busy), 32'd0);
                end
                if (tx_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data 0x%0h gnt 0x%0h, required no beat", tx_data, gnt);
                    end else begin
                        e = exp_q[0];
                        check("tx_data", 32'(tx_data), 32'(e.data));
                        check("tx_last", 32'(tx_last), 32'(e.last));
                        check("gnt", 32'(gnt), 32'(e.gnt));
                        check("busy", 32'(busy), 32'd1);
                        check("data_ack", 32'(data_ack), tx_ready ? 32'(e.ack) : 32'd0);
                        if (tx_ready) void'(exp_q.pop_front());
                    end
                    if (tx_ready) begin
                        for (int i = 0; i < NUM_REQ; i++) begin
                            if (data_ack[i]) begin
                                ack_seen[i] = 1'b1;
                                ack_cnt[i]++;
                            end
                            if (tx_last && gnt[i]) last_seen[i] = 1'b1;
                        end
                    end
                end else begin
                    check("idle_ack", 32'(data_ack), 32'd0);
                    check("idle_last", 32'(tx_last), 32'd0);
                end
                prev_stall   = tx_valid && !tx_ready;
                prev_last_hs = tx_valid && tx_ready && tx_last;
            end
        end
    end

    initial begin
        int cyc;
        int mask;
        reset       = 1'b0;
        in_reset    = 1'b1;
        tx_ready    = 1'b1;
        ready_mode  = 0;
        ready_phase = 0;
        model_lw    = NUM_REQ - 1;
        clear_plan();
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_pkt[i] = 0;
            ptr[i]     = 0;
            dropped[i] = 1'b0;
        end
        drive_sources();
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(data_ack), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_last", 32'(tx_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        #1 in_reset = 1'b0;

        // All four requesting, source 0 twice: order 0,1,2,3,0
        add_pkt(0, 1); add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1); add_pkt(3, 1);
        run_scenario(0);

        // "123456789" from source 0
        add_pkt(0, 9);
        for (int b = 0; b < 9; b++) pay[0][0][b] = 8'h31 + 8'(b);
        run_scenario(0);

        // Zero-length packet from source 2
        add_pkt(2, 0);
        run_scenario(0);

        // Same 3-byte packet without and with stalls
        add_pkt(0, 3);
        run_scenario(0);
        npkt[0] = 1;
        run_scenario(1);
        clear_plan();

        // Source 1 drops req after its first byte; source 3 still pending
        add_pkt(1, 4); add_pkt(3, 2);
        drop_early[1] = 1'b1;
        run_scenario(0);

        // Maximum length
        add_pkt(3, 15);
        run_scenario(1);

        // Reset in the middle of a packet
        add_pkt(0, 8);
        ready_mode = 0;
        @(posedge clk);
        #2;
        start_plan();
        cyc = 0;
        while (ack_cnt[0] < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_reset_acks", 32'(ack_cnt[0]), 32'd2);
        @(posedge clk);
        #3;
        reset    = 1'b0;
        in_reset = 1'b1;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_valid", 32'(tx_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_last", 32'(tx_last), 32'd0);
        check("async_ack", 32'(data_ack), 32'd0);
        exp_q.delete();
        clear_plan();
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_seen[i]  = 1'b0;
            last_seen[i] = 1'b0;
        end
        drive_sources();
        model_lw = NUM_REQ - 1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 in_reset = 1'b0;
        add_pkt(0, 2); add_pkt(1, 3);
        run_scenario(0);

        // Randomized traffic
        for (int t = 0; t < 20; t++) begin
            mask = $urandom_range(1, (1 << NUM_REQ) - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) begin
                    repeat ($urandom_range(1, MAXPK)) add_pkt(i, $urandom_range(0, 15));
                end
            end
            run_scenario($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
